img_out_ctrl: RTL
=================

Name: img_out_ctrl

Overview:
- Sequencer for the 2500-byte dual-port output image RAM (port A write, port B read/write, 1-cycle registered read on port B).
- Fills the RAM with one downsampled frame from the downsampler stream through port A.
- Then drains the frame in address order through port B to a downstream consumer (DDR/UART path) with valid/ready flow control at full throughput.
- Fill and drain phases are mutually exclusive, so port collisions cannot occur.

Parameters:
NUM_PIX, 2500, pixels per frame (RAM depth; 50x50 image); must be 1..2^ADDR_W
ADDR_W, 13, RAM address width
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
pix_in_data  in  DATA_W  pixel from downsampler
pix_in_valid  in  1  pix_in_data valid
pix_in_ready  out  1  controller accepts pixel this cycle
pix_out_data  out  DATA_W  pixel to consumer
pix_out_valid  out  1  pix_out_data valid
pix_out_ready  in  1  consumer accepts pixel this cycle
ram_data_a  out  DATA_W  RAM port A write data
ram_addr_a  out  ADDR_W  RAM port A address
ram_we_a  out  1  RAM port A write enable
ram_data_b  out  DATA_W  RAM port B write data, constant 0
ram_addr_b  out  ADDR_W  RAM port B address
ram_we_b  out  1  RAM port B write enable, constant 0
ram_q_b  in  DATA_W  RAM port B registered read data
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_cnt=0, rd_cnt=0, out_cnt=0.
  - Skid FIFO emptied; inflight=0.
  - All outputs 0. RAM contents are not touched.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - pix_in_ready=0, pix_out_valid=0.
  - start=1 -> FILL; clear wr_cnt, rd_cnt and out_cnt.
  - start in any other state is ignored.
- FILL:
  - pix_in_ready=1.
  - A pixel is accepted when pix_in_valid=1. Same cycle (combinational): ram_we_a=1, ram_addr_a=wr_cnt, ram_data_a=pix_in_data.
  - wr_cnt increments on each accept.
  - Accept with wr_cnt==NUM_PIX-1 -> DRAIN next cycle.
  - ram_we_a=0 whenever no accept. ram_addr_a and ram_data_a still track wr_cnt and pix_in_data.
- DRAIN:
  - pix_in_ready=0.
  - ram_addr_b=rd_cnt at all times (a read with no issue is harmless).
  - pop = pix_out_valid & pix_out_ready.
  - issue = (rd_cnt<NUM_PIX) & (fifo_occ + inflight - pop < 2).
  - On issue: rd_cnt++, and inflight=1 for the next cycle.
  - In the cycle after an issue, ram_q_b is pushed into the 2-entry skid FIFO.
  - Push and pop may occur in the same cycle.
  - pix_out_valid = FIFO not empty; pix_out_data = FIFO head.
  - Data is held stable while valid=1 and ready=0.
  - Throughput is 1 pixel/cycle under continuous ready.
  - First pix_out_valid appears 2 cycles after entry to DRAIN.
  - out_cnt increments on each pop. Pop with out_cnt==NUM_PIX-1 -> DONE.
- DONE:
  - frame_done=1 for exactly one cycle -> IDLE.
  - A start in the DONE cycle is ignored.
- Counters are ADDR_W+1 bits. Addresses never exceed NUM_PIX-1; no wrap-around within a frame.
- Reset mid-FILL or mid-DRAIN aborts the frame: FIFO contents are discarded and no frame_done is issued.
- NUM_PIX=1: FILL lasts one accept; drain emits one pixel, then DONE.
- The RAM is written only through port A and read only through port B. ram_we_b never asserts.

Test Plan:
1. NUM_PIX=4; start; pixels 0x11,0x22,0x33,0x44 with continuous valid -> ram_we_a high 4 cycles at addr 0..3; DRAIN entered; pix_out stream 0x11,0x22,0x33,0x44 on 4 consecutive cycles with ready=1; frame_done one cycle after the last pop; busy falls with it.
2. NUM_PIX=4; pix_in_valid toggling 1,0,1,0... -> writes only on valid cycles; addresses 0..3 contiguous; wr_cnt unchanged on idle cycles.
3. NUM_PIX=6; pix_out_ready pattern 1,0,0,1,1,0,1... -> no duplicated or dropped pixel; data stable while stalled; FIFO occupancy never >2; output order 0..5.
4. Default NUM_PIX=2500; data=addr[7:0] -> 2500 outputs matching, last address 2499, exactly one frame_done; start pulses during FILL/DRAIN are ignored.
5. Assert rst_n=0 mid-DRAIN after 3 pops -> all outputs 0 immediately (async); after release, state IDLE with no frame_done; a new start performs a full fill/drain correctly.
6. NUM_PIX=1; single pixel 0xA5 -> one write at addr 0; one output 0xA5; frame_done pulse.

Source files
------------

// File: rtl/img_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : img_out_ctrl
// Description : Fills the output image RAM with one frame, then drains it in
//               address order to a valid/ready consumer through a skid FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module img_out_ctrl #(
    parameter int NUM_PIX = 2500,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in_data,
    input  logic              pix_in_valid,
    output logic              pix_in_ready,
    output logic [DATA_W-1:0] pix_out_data,
    output logic              pix_out_valid,
    input  logic              pix_out_ready,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_we_a,
    output logic [DATA_W-1:0] ram_data_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b,
    output logic              busy,
    output logic              frame_done
);

    localparam int                 c_CNT_W = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_NUM   = c_CNT_W'(NUM_PIX);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_PIX - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_wr_cnt;
    logic [c_CNT_W-1:0]  r_rd_cnt;
    logic [c_CNT_W-1:0]  r_out_cnt;
    logic [DATA_W-1:0]   r_fifo [2];
    logic [1:0]          r_occ;
    logic                r_inflight;

    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [1:0]          w_level;
    logic [1:0]          w_slot_full;
    logic                w_slot;

    assign w_accept    = (r_state == S_FILL) && pix_in_valid;
    assign w_pop       = (r_occ != 2'd0) && pix_out_ready;
    assign w_push      = r_inflight;
    // Entries the FIFO will hold once the outstanding read lands, after this pop.
    assign w_level     = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue     = (r_state == S_DRAIN) && (r_rd_cnt < c_NUM) && (w_level < 2'd2);
    assign w_slot_full = r_occ - {1'b0, w_pop};
    assign w_slot      = w_slot_full[0];

    always_comb begin
        w_state_nxt   = r_state;
        pix_in_ready  = 1'b0;
        ram_we_a      = 1'b0;
        ram_data_a    = '0;
        ram_addr_a    = r_wr_cnt[ADDR_W-1:0];
        ram_addr_b    = r_rd_cnt[ADDR_W-1:0];
        ram_data_b    = '0;
        ram_we_b      = 1'b0;
        pix_out_valid = (r_occ != 2'd0);
        pix_out_data  = r_fifo[0];
        busy          = (r_state != S_IDLE);
        frame_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                pix_in_ready = 1'b1;
                ram_we_a     = w_accept;
                ram_data_a   = pix_in_data;
                if (w_accept && (r_wr_cnt == c_LAST)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && (r_out_cnt == c_LAST)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if ((r_state == S_IDLE) && start) begin
                r_wr_cnt  <= '0;
                r_rd_cnt  <= '0;
                r_out_cnt <= '0;
            end
            if (w_accept) r_wr_cnt  <= r_wr_cnt + c_ONE;
            if (w_issue)  r_rd_cnt  <= r_rd_cnt + c_ONE;
            if (w_pop)    r_out_cnt <= r_out_cnt + c_ONE;
            // A push into the slot vacated by a simultaneous pop overrides the shift.
            if (w_pop)    r_fifo[0] <= r_fifo[1];
            if (w_push)   r_fifo[w_slot] <= ram_q_b;
        end
    end

endmodule
`default_nettype wire
